// File: rtl/iomem_cfgchain_loader_pkg.sv
// Shared constants, register map and shifter state encoding
// for the iomem configuration-chain loader.
package iomem_cfgchain_pkg;

   localparam logic [31:0] CFG_BASE_ADDR = 32'h0300_0000;
   localparam int          CFG_CNT_W     = 16;

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_DATA   = 2'd2;
   localparam logic [1:0] REG_LEN    = 2'd3;

   localparam int CTRL_START  = 0;
   localparam int CTRL_ABORT  = 1;

   localparam int STAT_BUSY   = 0;
   localparam int STAT_FULL   = 1;
   localparam int STAT_DONE   = 2;
   localparam int STAT_REM_LO = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LO,
      S_HI,
      S_DONE
   } cfg_state_t;

   function automatic logic [31:0] status_word(
      input logic        busy,
      input logic        full,
      input logic        done,
      input logic [15:0] rem
   );
      logic [31:0] w;
      w = '0;
      w[STAT_BUSY] = busy;
      w[STAT_FULL] = full;
      w[STAT_DONE] = done;
      w[STAT_REM_LO +: 16] = rem;
      return w;
   endfunction

endpackage

// File: rtl/iomem_cfgchain_loader_if.sv
// PicoRV32-style iomem bus bundle between the CPU side
// and the configuration-chain loader.
interface iomem_cfgchain_loader_if;

   logic        iomem_valid;
   logic        iomem_ready;
   logic [3:0]  iomem_wstrb;
   logic [31:0] iomem_addr;
   logic [31:0] iomem_wdata;
   logic [31:0] iomem_rdata;

   modport master (
      output iomem_valid,
      output iomem_wstrb,
      output iomem_addr,
      output iomem_wdata,
      input  iomem_ready,
      input  iomem_rdata
   );

   modport slave (
      input  iomem_valid,
      input  iomem_wstrb,
      input  iomem_addr,
      input  iomem_wdata,
      output iomem_ready,
      output iomem_rdata
   );

endinterface

// File: rtl/iomem_cfgchain_loader_shifter.sv
// Chain sequencer: fetches words from the holding buffer and
// shifts them LSB-first with a generated prog_clk, capturing tail.
module cfgchain_shifter
   import iomem_cfgchain_pkg::*;
#(
   parameter int CNT_W = CFG_CNT_W
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             i_start,
   input  logic             i_abort,
   input  logic [CNT_W-1:0] i_len,
   input  logic             i_buf_full,
   input  logic [31:0]      i_buf,
   input  logic             i_tail,
   output logic             o_fetch,
   output logic             o_busy,
   output logic             o_done,
   output logic [CNT_W-1:0] o_remaining,
   output logic [31:0]      o_tail_cap,
   output logic             o_prog_clk,
   output logic             o_head
);

   cfg_state_t       r_state;
   logic [31:0]      r_sh;
   logic [5:0]       r_bitcnt;
   logic [CNT_W-1:0] r_remaining;
   logic [31:0]      r_tail_cap;
   logic             r_prog_clk;
   logic             r_head;
   logic             r_done;

   assign o_fetch     = (r_state == S_FETCH) && i_buf_full && !i_abort;
   assign o_busy      = (r_state == S_FETCH) || (r_state == S_LO)
                     || (r_state == S_HI);
   assign o_done      = r_done;
   assign o_remaining = r_remaining;
   assign o_tail_cap  = r_tail_cap;
   assign o_prog_clk  = r_prog_clk;
   assign o_head      = r_head;

   // Tail is sampled on the edge that raises prog_clk, i.e. before
   // the chain flops advance, so it sees the previous chain output.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state     <= S_IDLE;
         r_sh        <= '0;
         r_bitcnt    <= '0;
         r_remaining <= '0;
         r_tail_cap  <= '0;
         r_prog_clk  <= 1'b0;
         r_head      <= 1'b0;
         r_done      <= 1'b0;
      end else if (i_abort) begin
         r_state    <= S_IDLE;
         r_prog_clk <= 1'b0;
         r_head     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE, S_DONE: begin
               r_prog_clk <= 1'b0;
               if (i_start) begin
                  if (i_len != '0) begin
                     r_state     <= S_FETCH;
                     r_remaining <= i_len;
                     r_done      <= 1'b0;
                  end else begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end
               end
            end
            S_FETCH: begin
               r_prog_clk <= 1'b0;
               if (i_buf_full) begin
                  r_sh     <= i_buf;
                  r_bitcnt <= '0;
                  r_head   <= i_buf[0];
                  r_state  <= S_LO;
               end
            end
            S_LO: begin
               r_prog_clk  <= 1'b1;
               r_tail_cap  <= {i_tail, r_tail_cap[31:1]};
               r_sh        <= {1'b0, r_sh[31:1]};
               r_remaining <= r_remaining - 1'b1;
               r_bitcnt    <= r_bitcnt + 1'b1;
               r_state     <= S_HI;
            end
            S_HI: begin
               r_prog_clk <= 1'b0;
               if (r_remaining == '0) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end else if (r_bitcnt == 6'd32) begin
                  r_state <= S_FETCH;
               end else begin
                  r_head  <= r_sh[0];
                  r_state <= S_LO;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/iomem_cfgchain_loader.sv
// iomem responder: register file, holding buffer and DATA-write
// stall logic in front of the configuration-chain shifter.
module iomem_cfgchain_loader
   import iomem_cfgchain_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = CFG_BASE_ADDR,
   parameter int          CNT_W     = CFG_CNT_W
) (
   input  logic                    clk,
   input  logic                    resetn,
   iomem_cfgchain_loader_if.slave  bus,
   output logic                    prog_clk,
   output logic                    ccff_head,
   input  logic                    ccff_tail,
   output logic                    cfg_done
);

   logic             r_ready;
   logic [31:0]      r_rdata;
   logic             r_start;
   logic             r_abort;
   logic [CNT_W-1:0] r_len;
   logic [31:0]      r_buf;
   logic             r_buf_full;

   logic             w_sel;
   logic [1:0]       w_reg;
   logic             w_wr;
   logic             w_stall;
   logic             w_acc;
   logic             w_fetch;
   logic             w_busy;
   logic             w_done;
   logic [CNT_W-1:0] w_remaining;
   logic [31:0]      w_tail_cap;
   logic [31:0]      w_rdata;
   logic [31:0]      w_len_ext;
   logic             w_unused;

   assign w_sel = bus.iomem_valid
               && (bus.iomem_addr[31:4] == BASE_ADDR[31:4]);
   assign w_reg = bus.iomem_addr[3:2];
   assign w_wr  = |bus.iomem_wstrb;

   // Only a DATA write that would clobber a word still owed to
   // an active shift waits; when idle the buffer is overwritten.
   assign w_stall = w_wr && (w_reg == REG_DATA)
                 && r_buf_full && w_busy;
   assign w_acc   = w_sel && !r_ready && !w_stall;

   assign w_unused = &{1'b0, bus.iomem_addr[1:0]};

   always_comb begin
      w_rdata = '0;
      unique case (w_reg)
         REG_CTRL:   w_rdata = '0;
         REG_STATUS: w_rdata = status_word(w_busy, r_buf_full,
                               w_done, 16'(w_remaining));
         REG_DATA:   w_rdata = w_tail_cap;
         REG_LEN:    w_rdata = 32'(r_len);
      endcase
   end

   always_comb begin
      w_len_ext = 32'(r_len);
      for (int b = 0; b < 4; b++) begin
         if (bus.iomem_wstrb[b]) begin
            w_len_ext[b*8 +: 8] = bus.iomem_wdata[b*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_ready    <= 1'b0;
         r_rdata    <= '0;
         r_start    <= 1'b0;
         r_abort    <= 1'b0;
         r_len      <= '0;
         r_buf      <= '0;
         r_buf_full <= 1'b0;
      end else begin
         r_ready <= w_acc;
         r_rdata <= w_acc ? w_rdata : '0;
         r_start <= w_acc && w_wr && (w_reg == REG_CTRL)
                 && bus.iomem_wdata[CTRL_START];
         r_abort <= w_acc && w_wr && (w_reg == REG_CTRL)
                 && bus.iomem_wdata[CTRL_ABORT];
         if (w_acc && w_wr && (w_reg == REG_LEN)) begin
            r_len <= w_len_ext[CNT_W-1:0];
         end
         if (w_fetch) begin
            r_buf_full <= 1'b0;
         end
         if (w_acc && w_wr && (w_reg == REG_DATA)) begin
            r_buf      <= bus.iomem_wdata;
            r_buf_full <= 1'b1;
         end
         if (r_abort) begin
            r_buf_full <= 1'b0;
         end
      end
   end

   assign bus.iomem_ready = r_ready;
   assign bus.iomem_rdata = r_rdata;

   cfgchain_shifter #(
      .CNT_W (CNT_W)
   ) u_shifter (
      .clk         (clk),
      .resetn      (resetn),
      .i_start     (r_start),
      .i_abort     (r_abort),
      .i_len       (r_len),
      .i_buf_full  (r_buf_full),
      .i_buf       (r_buf),
      .i_tail      (ccff_tail),
      .o_fetch     (w_fetch),
      .o_busy      (w_busy),
      .o_done      (w_done),
      .o_remaining (w_remaining),
      .o_tail_cap  (w_tail_cap),
      .o_prog_clk  (prog_clk),
      .o_head      (ccff_head)
   );

   assign cfg_done = w_done;

endmodule

// File: tb/tb_iomem_cfgchain_loader.sv
// Scoreboard bench: expected head bits queued as DATA words are
// written, popped on every prog_clk rise; bus reads checked inline.
module tb_iomem_cfgchain_loader;

   localparam logic [31:0] BASE = 32'h0300_0000;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic prog_clk;
   logic ccff_head;
   logic ccff_tail;
   logic cfg_done;
   logic tail_ff;

   int  n_err  = 0;
   int  n_chk  = 0;
   int  rises  = 0;
   logic pc_prev = 1'b0;
   bit  exp_q[$];

   iomem_cfgchain_loader_if bus();

   iomem_cfgchain_loader dut (
      .clk       (clk),
      .resetn    (resetn),
      .bus       (bus),
      .prog_clk  (prog_clk),
      .ccff_head (ccff_head),
      .ccff_tail (ccff_tail),
      .cfg_done  (cfg_done)
   );

   always #5 clk = ~clk;

   // Stand-in for a one-flop chain: tail is head delayed by one prog_clk.
   always @(posedge prog_clk or negedge resetn) begin
      if (!resetn) tail_ff <= 1'b0;
      else         tail_ff <= ccff_head;
   end
   assign ccff_tail = tail_ff;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (prog_clk === 1'b1 && pc_prev !== 1'b1) begin
         rises++;
         check("head_pending", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) check("head", 32'(ccff_head),
                                      32'(exp_q.pop_front()));
      end
      pc_prev = prog_clk;
   end

   task automatic push_word(input logic [31:0] w, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(w[i]);
   endtask

   task automatic bus_xfer(input logic [3:0] off, input logic [3:0] s,
                           input logic [31:0] d, output logic [31:0] q,
                           output int waits);
      @(posedge clk); #1;
      bus.iomem_valid = 1'b1;
      bus.iomem_addr  = BASE | 32'(off);
      bus.iomem_wstrb = s;
      bus.iomem_wdata = d;
      waits = 0;
      do begin
         @(posedge clk); #1;
         waits++;
      end while (!bus.iomem_ready && waits < 400);
      check("bus_ack", 32'(bus.iomem_ready), 32'd1);
      q = bus.iomem_rdata;
      bus.iomem_valid = 1'b0;
      bus.iomem_wstrb = 4'h0;
   endtask

   task automatic wr(input logic [3:0] off, input logic [31:0] d);
      logic [31:0] q;
      int w;
      bus_xfer(off, 4'hF, d, q, w);
   endtask

   task automatic rd(input logic [3:0] off, output logic [31:0] q);
      int w;
      bus_xfer(off, 4'h0, 32'h0, q, w);
   endtask

   task automatic wait_done(input int limit);
      int n = 0;
      while (cfg_done !== 1'b1 && n < limit) begin
         @(posedge clk); #1;
         n++;
      end
      check("done_wait", 32'(cfg_done), 32'd1);
   endtask

   task automatic wait_rises(input int target, input int limit);
      int n = 0;
      while (rises < target && n < limit) begin
         @(posedge clk); #2;
         n++;
      end
      check("rise_wait", 32'(rises >= target), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] q;
      int r0;
      int w;
      bus.iomem_valid = 1'b0;
      bus.iomem_addr  = '0;
      bus.iomem_wstrb = '0;
      bus.iomem_wdata = '0;

      // reset state and register reads
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 32'(bus.iomem_ready), 32'd0);
      check("rst_rdata", bus.iomem_rdata, 32'd0);
      check("rst_pclk", 32'(prog_clk), 32'd0);
      check("rst_head", 32'(ccff_head), 32'd0);
      check("rst_done", 32'(cfg_done), 32'd0);
      resetn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         rd(4'(i * 4), q);
         check("rst_reg", q, 32'd0);
      end

      // byte-strobed LEN write
      bus_xfer(4'hC, 4'b0010, 32'hFFFF_AB12, q, w);
      rd(4'hC, q);
      check("len_strobe", q, 32'h0000_AB00);

      // out-of-window address never acknowledged
      @(posedge clk); #1;
      bus.iomem_valid = 1'b1;
      bus.iomem_addr  = BASE + 32'h10;
      bus.iomem_wstrb = 4'h0;
      w = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (bus.iomem_ready) w++;
      end
      check("oow_ack", 32'(w), 32'd0);
      bus.iomem_valid = 1'b0;

      // 40-bit chain across two words, start latency
      wr(4'hC, 32'd40);
      push_word(32'hA5A5_0F0F, 32);
      wr(4'h8, 32'hA5A5_0F0F);
      r0 = rises;
      wr(4'h0, 32'h1);
      @(posedge clk); #1;
      check("t1_pclk", 32'(prog_clk), 32'd0);
      @(posedge clk); #1;
      check("t2_head", 32'(ccff_head), 32'd1);
      check("t2_pclk", 32'(prog_clk), 32'd0);
      @(posedge clk); #1;
      check("t3_pclk", 32'(prog_clk), 32'd1);
      push_word(32'h0000_00C3, 8);
      wr(4'h8, 32'h0000_00C3);
      wait_done(400);
      check("len40_rises", 32'(rises - r0), 32'd40);
      rd(4'h4, q);
      check("len40_status", q, 32'h0000_0004);
      check("len40_q", 32'(exp_q.size()), 32'd0);

      // starve after first word, resume on second DATA write
      wr(4'hC, 32'd64);
      push_word(32'hDEAD_BEEF, 32);
      wr(4'h8, 32'hDEAD_BEEF);
      r0 = rises;
      wr(4'h0, 32'h1);
      wait_rises(r0 + 32, 200);
      repeat (4) @(posedge clk);
      #1;
      check("starve_pclk", 32'(prog_clk), 32'd0);
      rd(4'h4, q);
      check("starve_status", q, 32'h0020_0001);
      push_word(32'h0BAD_F00D, 32);
      wr(4'h8, 32'h0BAD_F00D);
      wait_done(400);
      check("len64_rises", 32'(rises - r0), 32'd64);

      // DATA write stalled while the buffer is still owed
      wr(4'hC, 32'd96);
      push_word(32'h1111_8888, 32);
      wr(4'h8, 32'h1111_8888);
      r0 = rises;
      wr(4'h0, 32'h1);
      push_word(32'h7E57_C0DE, 32);
      wr(4'h8, 32'h7E57_C0DE);
      push_word(32'hC001_D00D, 32);
      bus_xfer(4'h8, 4'hF, 32'hC001_D00D, q, w);
      check("stall_wait", 32'(w > 8), 32'd1);
      @(posedge clk); #1;
      check("stall_pulse", 32'(bus.iomem_ready), 32'd0);
      wait_done(600);
      check("len96_rises", 32'(rises - r0), 32'd96);
      check("len96_q", 32'(exp_q.size()), 32'd0);

      // abort mid-shift clears buffer and done
      wr(4'hC, 32'd64);
      push_word(32'h5A5A_3C3C, 32);
      wr(4'h8, 32'h5A5A_3C3C);
      r0 = rises;
      wr(4'h0, 32'h1);
      wr(4'h8, 32'hFFFF_FFFF);
      wait_rises(r0 + 10, 200);
      wr(4'h0, 32'h2);
      @(posedge clk); #1;
      check("abort_pclk", 32'(prog_clk), 32'd0);
      check("abort_head", 32'(ccff_head), 32'd0);
      check("abort_done", 32'(cfg_done), 32'd0);
      exp_q.delete();
      rd(4'h4, q);
      check("abort_status", q & 32'h7, 32'd0);
      wr(4'hC, 32'd0);
      r0 = rises;
      wr(4'h0, 32'h1);
      w = 0;
      while (cfg_done !== 1'b1 && w < 2) begin
         @(posedge clk); #1;
         w++;
      end
      check("len0_done", 32'(cfg_done), 32'd1);
      repeat (4) @(posedge clk);
      #1;
      check("len0_rises", 32'(rises - r0), 32'd0);

      // reset while prog_clk is high
      wr(4'hC, 32'd32);
      push_word(32'h0F1E_2D3C, 32);
      wr(4'h8, 32'h0F1E_2D3C);
      r0 = rises;
      wr(4'h0, 32'h1);
      wait_rises(r0 + 5, 200);
      resetn = 1'b0;
      #1;
      check("mrst_pclk", 32'(prog_clk), 32'd0);
      check("mrst_head", 32'(ccff_head), 32'd0);
      check("mrst_done", 32'(cfg_done), 32'd0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
      rd(4'h4, q);
      check("mrst_status", q, 32'd0);

      // tail loopback through one chain flop
      wr(4'hC, 32'd32);
      push_word(32'h1234_5678, 32);
      wr(4'h8, 32'h1234_5678);
      wr(4'h0, 32'h1);
      wait_done(200);
      rd(4'h8, q);
      check("tail_cap", q, 32'h2468_ACF0);
      rd(4'h4, q);
      check("tail_status", q, 32'h0000_0004);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
